score_engine: RTL and testbench
===============================

# score_engine

Parametrised scoring engine for the rhythm game. It takes per-lane hit/miss pulses from any number of note lanes and maintains the score, combo, multiplier and best combo. A sequential binary-to-BCD converter produces the 5-digit value for the `placar` 7-segment driver. It sits between the lane `pattern` instances and `placar`, and replaces the single OR-reduced `ponto` counter.

## Interface
Parameters:
- LANES, 8, number of note lanes (1..16)
- SCORE_W, 17, score register width (must hold SCORE_MAX)
- SCORE_MAX, 99999, saturation value of score (≤ 99999, 5 BCD digits)
- COMBO_W, 8, combo/max_combo width; saturates at 2^COMBO_W−1
- COMBO_SHIFT, 3, combo hits per multiplier step = 2^COMBO_SHIFT
- MULT_MAX, 4, multiplier ceiling (1..7)

Ports:
- CLOCK_25  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- hit  in  LANES  per-lane note-hit pulse, one cycle per note
- miss  in  LANES  per-lane note-missed pulse
- clear  in  1  new-game clear, synchronous, one cycle
- freeze  in  1  game over; hit/miss ignored while high
- score  out  SCORE_W  current score
- combo  out  COMBO_W  current consecutive-hit count
- max_combo  out  COMBO_W  best combo since reset/clear
- multiplier  out  3  current multiplier, 1..MULT_MAX
- bcd  out  20  score as 5 BCD digits, [19:16] = ten-thousands
- bcd_busy  out  1  converter running; bcd holds the previous value

## Operation
- Valid hits: vh = hit & ~miss. On a lane with both hit and miss in the same cycle, miss wins.
- nh = popcount(vh); any_miss = |miss.
- Per accepted cycle (freeze=0, clear=0):
  - score ← min(score + nh·multiplier, SCORE_MAX). The multiplier is the value registered at the start of the cycle. Compute the sum at SCORE_W+4 bits before the saturation compare.
  - combo ← any_miss ? 0 : min(combo + nh, 2^COMBO_W−1)
  - multiplier ← min(1 + (combo_next >> COMBO_SHIFT), MULT_MAX)
  - max_combo ← max(max_combo, combo_next)
- Priority: rst > clear > freeze > hit/miss.
- clear zeroes score, combo and max_combo, sets multiplier=1, and requests a conversion.
- Converter FSM:
  - IDLE: when score changed last edge, or when a pending flag is set, latch the score snapshot, clear pending, and go to SHIFT.
  - SHIFT: double-dabble for SCORE_W iterations, one shift/add-3 per cycle. After the last iteration, load bcd and return to IDLE.
  - A score change while in SHIFT sets pending. The finished (stale) result is still written. A new conversion then follows immediately.
  - clear while in SHIFT aborts to IDLE with pending=1.
- Reset values: score=0, combo=0, max_combo=0, multiplier=1, bcd=0, bcd_busy=0, FSM IDLE, pending=0.

## Timing
- hit/miss sampled at edge E → score/combo/multiplier/max_combo valid after E (1-cycle latency).
- Score change at edge E → converter latches at E+1 (bcd_busy=1) → bcd updated and bcd_busy=0 at edge E+1+SCORE_W.
- Back-to-back hit cycles are all accepted with no stall. Scoring never waits on the converter.
- freeze asserted at edge E: inputs at E are ignored. An in-flight conversion completes normally.
- rst mid-conversion: everything returns to reset values on the next edge and no conversion runs.

## Configuration
- SCORE_ENGINE_COMBO_EN:
  - Defined: combo, max_combo and multiplier behave as above.
  - Undefined: combo and max_combo are tied to 0, multiplier is tied to 1, and score adds nh per cycle. Converter and saturation are unchanged.

## Test plan
Defaults unless stated; SCORE_ENGINE_COMBO_EN defined.
- rst, then hit=8'h01 for one cycle → next cycle: score=1, combo=1, multiplier=1; SCORE_W+1 cycles later: bcd=20'h00001, bcd_busy=0.
- hit=8'hFF for two consecutive cycles from reset → after cycle 1: score=8, combo=8, mult=2. After cycle 2: score=24, combo=16, mult=3. Then bcd=20'h00024.
- From combo=16/mult=3/score=24, hit=8'h0F with miss=8'h01 → score=33 (3 hits ×3), combo=0, mult=1, max_combo=16.
- SCORE_MAX=20 override; from score=18, mult=1, hit=8'hFF → score=20. A further hit=8'h01 leaves score=20 with combo still incrementing.
- hit during bcd_busy → pending conversion runs. Final bcd equals the final score, with no lost update.
- freeze=1 with hit=8'hFF → no change. clear mid-conversion → score=0, max_combo=0, mult=1. bcd=20'h00000 after SCORE_W+1 cycles. rst mid-SHIFT → bcd=0 and bcd_busy=0 next cycle.

Source files
------------

// File: rtl/score_engine_if.sv
// score_engine_if
// ---------------
// Bundles the game-side signals of the scoring engine. The game controller
// (master) drives the lane pulses and game-state controls; the engine
// (slave) drives the score state and the BCD conversion result.
//
// Signals:
//   hit        [LANES]    per-lane note-hit pulse
//   miss       [LANES]    per-lane note-missed pulse
//   clear                 new-game clear, one cycle
//   freeze                game over, hit/miss ignored while high
//   score      [SCORE_W]  current score
//   combo      [COMBO_W]  current consecutive-hit count
//   max_combo  [COMBO_W]  best combo since reset/clear
//   multiplier [3]        current multiplier
//   bcd        [20]       score as 5 BCD digits, [19:16] = ten-thousands
//   bcd_busy              converter running, bcd holds the previous value
interface score_engine_if #(
    parameter int LANES   = 8,
    parameter int SCORE_W = 17,
    parameter int COMBO_W = 8
);
    logic [LANES-1:0]   hit;
    logic [LANES-1:0]   miss;
    logic               clear;
    logic               freeze;
    logic [SCORE_W-1:0] score;
    logic [COMBO_W-1:0] combo;
    logic [COMBO_W-1:0] max_combo;
    logic [2:0]         multiplier;
    logic [19:0]        bcd;
    logic               bcd_busy;

    modport master (
        output hit, miss, clear, freeze,
        input  score, combo, max_combo, multiplier, bcd, bcd_busy
    );

    modport slave (
        input  hit, miss, clear, freeze,
        output score, combo, max_combo, multiplier, bcd, bcd_busy
    );
endinterface

// File: rtl/score_engine.sv
// score_engine
// ------------
// Rhythm-game scoring engine. Accepts per-lane hit/miss pulses from LANES
// note lanes and keeps score, combo, multiplier and best combo. A sequential
// double-dabble converter turns the score into 5 BCD digits for the 7-segment
// driver; scoring never waits on the converter.
//
// Ports:
//   CLOCK_25  in   system clock, the only clock
//   rst       in   synchronous active-high reset
//   bus       slave modport of score_engine_if (hit/miss/clear/freeze in,
//                  score/combo/max_combo/multiplier/bcd/bcd_busy out)
//
// Configuration macro:
//   SCORE_ENGINE_COMBO_EN  defined: combo, max_combo and multiplier active.
//                          undefined: combo/max_combo stay 0, multiplier stays
//                          1, score adds one point per valid hit.
module score_engine #(
    parameter int LANES       = 8,
    parameter int SCORE_W     = 17,
    parameter int SCORE_MAX   = 99999,
    parameter int COMBO_W     = 8,
    parameter int COMBO_SHIFT = 3,
    parameter int MULT_MAX    = 4
) (
    input  logic          CLOCK_25,
    input  logic          rst,
    score_engine_if.slave bus
);
    localparam int NH_W  = $clog2(LANES + 1);
    localparam int SUM_W = SCORE_W + 4;
    localparam int CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // ---------------------------------------------------------------
    // Scoring datapath
    // ---------------------------------------------------------------
    logic [SCORE_W-1:0] score_q, score_d;
    logic [COMBO_W-1:0] combo_q, combo_d;
    logic [COMBO_W-1:0] max_combo_q, max_combo_d;
    logic [2:0]         mult_q, mult_d;
    logic               chg_q, chg_d;

    logic [LANES-1:0]   vh;
    logic [NH_W-1:0]    nh;
    logic [SUM_W-1:0]   score_sum;
    logic [SCORE_W-1:0] score_acc;
    logic [COMBO_W-1:0] combo_acc;
    logic [COMBO_W-1:0] max_acc;
    logic [2:0]         mult_acc;
    int                 mult_calc;

`ifdef SCORE_ENGINE_COMBO_EN
    localparam int                 CS_W      = COMBO_W + NH_W;
    localparam logic [COMBO_W-1:0] COMBO_SAT = '1;
    logic [CS_W-1:0] combo_sum;
`endif

    always_comb begin
        // miss wins over hit on the same lane
        vh = bus.hit & ~bus.miss;
        nh = '0;
        for (int i = 0; i < LANES; i++) begin
            nh = nh + NH_W'(vh[i]);
        end

        // Widened sum so the saturation compare cannot be fooled by wrap.
        score_sum = SUM_W'(score_q) + SUM_W'(nh) * SUM_W'(mult_q);
        score_acc = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                    : score_sum[SCORE_W-1:0];

`ifdef SCORE_ENGINE_COMBO_EN
        combo_sum = CS_W'(combo_q) + CS_W'(nh);
        if (|bus.miss) begin
            combo_acc = '0;
        end else if (combo_sum > CS_W'(COMBO_SAT)) begin
            combo_acc = COMBO_SAT;
        end else begin
            combo_acc = combo_sum[COMBO_W-1:0];
        end
`else
        // With combo held at 0 the multiplier below folds to a constant 1.
        combo_acc = '0;
`endif

        mult_calc = 1 + int'(combo_acc >> COMBO_SHIFT);
        mult_acc  = (mult_calc > MULT_MAX) ? 3'(MULT_MAX) : 3'(mult_calc);
        max_acc   = (combo_acc > max_combo_q) ? combo_acc : max_combo_q;

        if (bus.clear) begin
            score_d     = '0;
            combo_d     = '0;
            max_combo_d = '0;
            mult_d      = 3'd1;
        end else if (bus.freeze) begin
            score_d     = score_q;
            combo_d     = combo_q;
            max_combo_d = max_combo_q;
            mult_d      = mult_q;
        end else begin
            score_d     = score_acc;
            combo_d     = combo_acc;
            max_combo_d = max_acc;
            mult_d      = mult_acc;
        end

        // Tells the converter, one edge later, that a new score exists.
        chg_d = (score_d != score_q);
    end

    // ---------------------------------------------------------------
    // Sequential binary-to-BCD converter (double dabble)
    // ---------------------------------------------------------------
    logic [0:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [19:0]        dd_bcd_q, dd_bcd_d;
    logic [SCORE_W-1:0] dd_bin_q, dd_bin_d;
    logic [19:0]        bcd_q, bcd_d;
    logic               pending_q, pending_d;

    logic [19:0]        dd_adj;
    logic [19:0]        dd_step_bcd;
    logic [SCORE_W-1:0] dd_step_bin;

    // Add-3 correction on every digit that is 5 or more before the shift.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_digit
            assign dd_adj[gi*4 +: 4] = (dd_bcd_q[gi*4 +: 4] >= 4'd5)
                                     ? dd_bcd_q[gi*4 +: 4] + 4'd3
                                     : dd_bcd_q[gi*4 +: 4];
        end
    endgenerate

    assign dd_step_bcd = (dd_adj << 1) | {19'd0, dd_bin_q[SCORE_W-1]};
    assign dd_step_bin = dd_bin_q << 1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dd_bcd_d  = dd_bcd_q;
        dd_bin_d  = dd_bin_q;
        bcd_d     = bcd_q;
        pending_d = pending_q;

        if (bus.clear) begin
            // Abort any running conversion; the cleared score is converted next.
            state_d   = ST_IDLE;
            pending_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (chg_q || pending_q) begin
                        dd_bin_d  = score_q;
                        dd_bcd_d  = '0;
                        cnt_d     = '0;
                        pending_d = 1'b0;
                        state_d   = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    dd_bcd_d = dd_step_bcd;
                    dd_bin_d = dd_step_bin;
                    cnt_d    = cnt_q + CNT_W'(1);
                    // A score change mid-conversion is never lost: the
                    // current (stale) result still lands, then we rerun.
                    if (chg_q) begin
                        pending_d = 1'b1;
                    end
                    if (cnt_q == CNT_W'(SCORE_W - 1)) begin
                        bcd_d   = dd_step_bcd;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_25) begin
        if (rst) begin
            score_q     <= '0;
            combo_q     <= '0;
            max_combo_q <= '0;
            mult_q      <= 3'd1;
            chg_q       <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dd_bcd_q    <= '0;
            dd_bin_q    <= '0;
            bcd_q       <= '0;
            pending_q   <= 1'b0;
        end else begin
            score_q     <= score_d;
            combo_q     <= combo_d;
            max_combo_q <= max_combo_d;
            mult_q      <= mult_d;
            chg_q       <= chg_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dd_bcd_q    <= dd_bcd_d;
            dd_bin_q    <= dd_bin_d;
            bcd_q       <= bcd_d;
            pending_q   <= pending_d;
        end
    end

    assign bus.score      = score_q;
    assign bus.combo      = combo_q;
    assign bus.max_combo  = max_combo_q;
    assign bus.multiplier = mult_q;
    assign bus.bcd        = bcd_q;
    assign bus.bcd_busy   = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_score_engine.sv
// tb_score_engine
// ---------------
// Directed testbench for score_engine. Two instances: dut_a with default
// parameters and dut_b with SCORE_MAX=20 for the saturation case. Expected
// values for combo/multiplier depend on SCORE_ENGINE_COMBO_EN.
module tb_score_engine;
`ifdef SCORE_ENGINE_COMBO_EN
    localparam bit COMBO_ON = 1'b1;
`else
    localparam bit COMBO_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;

    score_engine_if #(.LANES(8), .SCORE_W(17), .COMBO_W(8)) bus_a ();
    score_engine_if #(.LANES(8), .SCORE_W(17), .COMBO_W(8)) bus_b ();

    score_engine #(
        .LANES(8), .SCORE_W(17), .SCORE_MAX(99999),
        .COMBO_W(8), .COMBO_SHIFT(3), .MULT_MAX(4)
    ) dut_a (
        .CLOCK_25(clk),
        .rst     (rst),
        .bus     (bus_a.slave)
    );

    score_engine #(
        .LANES(8), .SCORE_W(17), .SCORE_MAX(20),
        .COMBO_W(8), .COMBO_SHIFT(3), .MULT_MAX(4)
    ) dut_b (
        .CLOCK_25(clk),
        .rst     (rst),
        .bus     (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
    endtask

    task automatic drive_a(input logic [7:0] h, input logic [7:0] m);
        bus_a.hit  = h;
        bus_a.miss = m;
        cyc(1);
        bus_a.hit  = 8'h00;
        bus_a.miss = 8'h00;
    endtask

    task automatic drive_b(input logic [7:0] h, input logic [7:0] m);
        bus_b.hit  = h;
        bus_b.miss = m;
        cyc(1);
        bus_b.hit  = 8'h00;
        bus_b.miss = 8'h00;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus_a.score !== 17'd0) begin bad++; $display("FAIL reset_score got=%0d want=0", bus_a.score); end
        total++; if (bus_a.combo !== 8'd0) begin bad++; $display("FAIL reset_combo got=%0d want=0", bus_a.combo); end
        total++; if (bus_a.max_combo !== 8'd0) begin bad++; $display("FAIL reset_max_combo got=%0d want=0", bus_a.max_combo); end
        total++; if (bus_a.multiplier !== 3'd1) begin bad++; $display("FAIL reset_mult got=%0d want=1", bus_a.multiplier); end
        total++; if (bus_a.bcd !== 20'h00000) begin bad++; $display("FAIL reset_bcd got=%05h want=00000", bus_a.bcd); end
        total++; if (bus_a.bcd_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", bus_a.bcd_busy); end
        $display("test_reset: score=%0d mult=%0d bcd=%05h", bus_a.score, bus_a.multiplier, bus_a.bcd);
    endtask

    task automatic test_single_hit();
        logic [7:0] ec;
        ec = COMBO_ON ? 8'd1 : 8'd0;
        do_reset();
        drive_a(8'h01, 8'h00);
        total++; if (bus_a.score !== 17'd1) begin bad++; $display("FAIL single_score got=%0d want=1", bus_a.score); end
        total++; if (bus_a.combo !== ec) begin bad++; $display("FAIL single_combo got=%0d want=%0d", bus_a.combo, ec); end
        total++; if (bus_a.multiplier !== 3'd1) begin bad++; $display("FAIL single_mult got=%0d want=1", bus_a.multiplier); end
        cyc(1);
        total++; if (bus_a.bcd_busy !== 1'b1) begin bad++; $display("FAIL single_busy_start got=%0b want=1", bus_a.bcd_busy); end
        cyc(16);
        total++; if (bus_a.bcd_busy !== 1'b1) begin bad++; $display("FAIL single_busy_late got=%0b want=1", bus_a.bcd_busy); end
        cyc(1);
        total++; if (bus_a.bcd !== 20'h00001) begin bad++; $display("FAIL single_bcd got=%05h want=00001", bus_a.bcd); end
        total++; if (bus_a.bcd_busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%0b want=0", bus_a.bcd_busy); end
        $display("test_single_hit: score=%0d combo=%0d bcd=%05h", bus_a.score, bus_a.combo, bus_a.bcd);
    endtask

    task automatic test_multiplier();
        logic [16:0] es;
        logic [7:0]  ec;
        logic [2:0]  em;
        logic [19:0] eb;
        do_reset();
        bus_a.hit = 8'hFF;
        cyc(1);
        ec = COMBO_ON ? 8'd8 : 8'd0;
        em = COMBO_ON ? 3'd2 : 3'd1;
        total++; if (bus_a.score !== 17'd8) begin bad++; $display("FAIL mult1_score got=%0d want=8", bus_a.score); end
        total++; if (bus_a.combo !== ec) begin bad++; $display("FAIL mult1_combo got=%0d want=%0d", bus_a.combo, ec); end
        total++; if (bus_a.multiplier !== em) begin bad++; $display("FAIL mult1_mult got=%0d want=%0d", bus_a.multiplier, em); end
        cyc(1);
        bus_a.hit = 8'h00;
        es = COMBO_ON ? 17'd24 : 17'd16;
        ec = COMBO_ON ? 8'd16 : 8'd0;
        em = COMBO_ON ? 3'd3 : 3'd1;
        total++; if (bus_a.score !== es) begin bad++; $display("FAIL mult2_score got=%0d want=%0d", bus_a.score, es); end
        total++; if (bus_a.combo !== ec) begin bad++; $display("FAIL mult2_combo got=%0d want=%0d", bus_a.combo, ec); end
        total++; if (bus_a.multiplier !== em) begin bad++; $display("FAIL mult2_mult got=%0d want=%0d", bus_a.multiplier, em); end
        cyc(45);
        eb = COMBO_ON ? 20'h00024 : 20'h00016;
        total++; if (bus_a.bcd !== eb) begin bad++; $display("FAIL mult_bcd got=%05h want=%05h", bus_a.bcd, eb); end
        $display("test_multiplier: score=%0d combo=%0d mult=%0d bcd=%05h", bus_a.score, bus_a.combo, bus_a.multiplier, bus_a.bcd);
    endtask

    task automatic test_miss_wins();
        logic [16:0] es;
        logic [7:0]  emc;
        drive_a(8'h0F, 8'h01);
        es  = COMBO_ON ? 17'd33 : 17'd19;
        emc = COMBO_ON ? 8'd16 : 8'd0;
        total++; if (bus_a.score !== es) begin bad++; $display("FAIL miss_score got=%0d want=%0d", bus_a.score, es); end
        total++; if (bus_a.combo !== 8'd0) begin bad++; $display("FAIL miss_combo got=%0d want=0", bus_a.combo); end
        total++; if (bus_a.multiplier !== 3'd1) begin bad++; $display("FAIL miss_mult got=%0d want=1", bus_a.multiplier); end
        total++; if (bus_a.max_combo !== emc) begin bad++; $display("FAIL miss_max_combo got=%0d want=%0d", bus_a.max_combo, emc); end
        $display("test_miss_wins: score=%0d combo=%0d max_combo=%0d", bus_a.score, bus_a.combo, bus_a.max_combo);
    endtask

    task automatic test_saturation();
        logic [7:0] ec;
        do_reset();
        drive_b(8'h7F, 8'h80);
        drive_b(8'h7F, 8'h80);
        drive_b(8'h0F, 8'h10);
        total++; if (bus_b.score !== 17'd18) begin bad++; $display("FAIL sat_pre_score got=%0d want=18", bus_b.score); end
        total++; if (bus_b.multiplier !== 3'd1) begin bad++; $display("FAIL sat_pre_mult got=%0d want=1", bus_b.multiplier); end
        drive_b(8'hFF, 8'h00);
        ec = COMBO_ON ? 8'd8 : 8'd0;
        total++; if (bus_b.score !== 17'd20) begin bad++; $display("FAIL sat_score got=%0d want=20", bus_b.score); end
        total++; if (bus_b.combo !== ec) begin bad++; $display("FAIL sat_combo got=%0d want=%0d", bus_b.combo, ec); end
        drive_b(8'h01, 8'h00);
        ec = COMBO_ON ? 8'd9 : 8'd0;
        total++; if (bus_b.score !== 17'd20) begin bad++; $display("FAIL sat_hold_score got=%0d want=20", bus_b.score); end
        total++; if (bus_b.combo !== ec) begin bad++; $display("FAIL sat_hold_combo got=%0d want=%0d", bus_b.combo, ec); end
        total++; if (bus_b.max_combo !== ec) begin bad++; $display("FAIL sat_max_combo got=%0d want=%0d", bus_b.max_combo, ec); end
        cyc(60);
        total++; if (bus_b.bcd !== 20'h00020) begin bad++; $display("FAIL sat_bcd got=%05h want=00020", bus_b.bcd); end
        $display("test_saturation: score=%0d combo=%0d bcd=%05h", bus_b.score, bus_b.combo, bus_b.bcd);
    endtask

    task automatic test_back_to_back();
        logic [7:0] ec;
        do_reset();
        drive_a(8'h01, 8'h00);
        cyc(5);
        total++; if (bus_a.bcd_busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%0b want=1", bus_a.bcd_busy); end
        drive_a(8'h03, 8'h00);
        cyc(2);
        drive_a(8'h04, 8'h00);
        ec = COMBO_ON ? 8'd4 : 8'd0;
        total++; if (bus_a.score !== 17'd4) begin bad++; $display("FAIL b2b_score got=%0d want=4", bus_a.score); end
        total++; if (bus_a.combo !== ec) begin bad++; $display("FAIL b2b_combo got=%0d want=%0d", bus_a.combo, ec); end
        cyc(60);
        total++; if (bus_a.bcd !== 20'h00004) begin bad++; $display("FAIL b2b_bcd got=%05h want=00004", bus_a.bcd); end
        total++; if (bus_a.bcd_busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end got=%0b want=0", bus_a.bcd_busy); end
        $display("test_back_to_back: score=%0d bcd=%05h", bus_a.score, bus_a.bcd);
    endtask

    task automatic test_freeze();
        logic [7:0] ec;
        bus_a.freeze = 1'b1;
        drive_a(8'hFF, 8'h00);
        bus_a.freeze = 1'b0;
        ec = COMBO_ON ? 8'd4 : 8'd0;
        total++; if (bus_a.score !== 17'd4) begin bad++; $display("FAIL freeze_score got=%0d want=4", bus_a.score); end
        total++; if (bus_a.combo !== ec) begin bad++; $display("FAIL freeze_combo got=%0d want=%0d", bus_a.combo, ec); end
        total++; if (bus_a.bcd_busy !== 1'b0) begin bad++; $display("FAIL freeze_busy got=%0b want=0", bus_a.bcd_busy); end
        $display("test_freeze: score=%0d combo=%0d", bus_a.score, bus_a.combo);
    endtask

    task automatic test_clear_mid();
        drive_a(8'h01, 8'h00);
        cyc(3);
        total++; if (bus_a.bcd_busy !== 1'b1) begin bad++; $display("FAIL clr_busy_pre got=%0b want=1", bus_a.bcd_busy); end
        bus_a.clear = 1'b1;
        cyc(1);
        bus_a.clear = 1'b0;
        total++; if (bus_a.score !== 17'd0) begin bad++; $display("FAIL clr_score got=%0d want=0", bus_a.score); end
        total++; if (bus_a.combo !== 8'd0) begin bad++; $display("FAIL clr_combo got=%0d want=0", bus_a.combo); end
        total++; if (bus_a.max_combo !== 8'd0) begin bad++; $display("FAIL clr_max_combo got=%0d want=0", bus_a.max_combo); end
        total++; if (bus_a.multiplier !== 3'd1) begin bad++; $display("FAIL clr_mult got=%0d want=1", bus_a.multiplier); end
        total++; if (bus_a.bcd_busy !== 1'b0) begin bad++; $display("FAIL clr_abort got=%0b want=0", bus_a.bcd_busy); end
        cyc(1);
        total++; if (bus_a.bcd_busy !== 1'b1) begin bad++; $display("FAIL clr_restart got=%0b want=1", bus_a.bcd_busy); end
        cyc(16);
        total++; if (bus_a.bcd !== 20'h00004) begin bad++; $display("FAIL clr_bcd_hold got=%05h want=00004", bus_a.bcd); end
        cyc(1);
        total++; if (bus_a.bcd !== 20'h00000) begin bad++; $display("FAIL clr_bcd got=%05h want=00000", bus_a.bcd); end
        total++; if (bus_a.bcd_busy !== 1'b0) begin bad++; $display("FAIL clr_busy_end got=%0b want=0", bus_a.bcd_busy); end
        $display("test_clear_mid: score=%0d bcd=%05h", bus_a.score, bus_a.bcd);
    endtask

    task automatic test_rst_mid();
        drive_a(8'hFF, 8'h00);
        total++; if (bus_a.score !== 17'd8) begin bad++; $display("FAIL rstm_score got=%0d want=8", bus_a.score); end
        cyc(25);
        total++; if (bus_a.bcd !== 20'h00008) begin bad++; $display("FAIL rstm_bcd_pre got=%05h want=00008", bus_a.bcd); end
        drive_a(8'h01, 8'h00);
        cyc(3);
        total++; if (bus_a.bcd_busy !== 1'b1) begin bad++; $display("FAIL rstm_busy_pre got=%0b want=1", bus_a.bcd_busy); end
        do_reset();
        total++; if (bus_a.bcd !== 20'h00000) begin bad++; $display("FAIL rstm_bcd got=%05h want=00000", bus_a.bcd); end
        total++; if (bus_a.bcd_busy !== 1'b0) begin bad++; $display("FAIL rstm_busy got=%0b want=0", bus_a.bcd_busy); end
        total++; if (bus_a.score !== 17'd0) begin bad++; $display("FAIL rstm_score0 got=%0d want=0", bus_a.score); end
        total++; if (bus_a.multiplier !== 3'd1) begin bad++; $display("FAIL rstm_mult got=%0d want=1", bus_a.multiplier); end
        cyc(25);
        total++; if (bus_a.bcd_busy !== 1'b0) begin bad++; $display("FAIL rstm_idle got=%0b want=0", bus_a.bcd_busy); end
        total++; if (bus_a.bcd !== 20'h00000) begin bad++; $display("FAIL rstm_bcd_late got=%05h want=00000", bus_a.bcd); end
        $display("test_rst_mid: score=%0d bcd=%05h busy=%0b", bus_a.score, bus_a.bcd, bus_a.bcd_busy);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        bus_a.hit    = 8'h00;
        bus_a.miss   = 8'h00;
        bus_a.clear  = 1'b0;
        bus_a.freeze = 1'b0;
        bus_b.hit    = 8'h00;
        bus_b.miss   = 8'h00;
        bus_b.clear  = 1'b0;
        bus_b.freeze = 1'b0;
        cyc(2);

        test_reset();
        test_single_hit();
        test_multiplier();
        test_miss_wins();
        test_saturation();
        test_back_to_back();
        test_freeze();
        test_clear_mid();
        test_rst_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
